// File: rtl/bep_frame_controller_pkg.sv
// Shared types and constants for the BEP frame controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bep_frame_controller_pkg;

  // Controller states, in frame order
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HUNT    = 3'd1,
    ST_LENGTH  = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CHECK   = 3'd4,
    ST_RECOVER = 3'd5
  } state_t;

  // Error codes reported on error_code
  localparam logic [1:0] ERR_TIMEOUT  = 2'd0;
  localparam logic [1:0] ERR_LENGTH   = 2'd1;
  localparam logic [1:0] ERR_CSUM     = 2'd2;
  localparam logic [1:0] ERR_OVERFLOW = 2'd3;

  // Defaults for the controller parameters
  localparam logic [7:0] SYNC_BYTE_DEF      = 8'hD5;
  localparam int         MAX_LEN_DEF        = 16;
  localparam int         TIMEOUT_CYCLES_DEF = 40;
  localparam int         FIFO_DEPTH_DEF     = 4;

  // Nominal decoder bit period in clocks
  localparam int BIT_PERIOD = 18;

  // One payload buffer entry: frame position flags plus the byte
  typedef struct packed {
    logic       first;
    logic       last;
    logic [7:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/bep_frame_controller_byte_fifo.sv
// Small synchronous FIFO holding payload entries for the host.
// Latency: a push is visible at the head on the next cycle.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
module bep_frame_controller_byte_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head_dat,
  output logic             o_vld,
  output logic             o_full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_rd;
  logic             w_wr;

  // Pop only when something is stored; push when room or when a pop frees a slot
  always_comb begin
    w_rd = i_pop & (r_count != '0);
    w_wr = i_push & (~o_full | w_rd);
  end

  // Storage, pointers and occupancy
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= i_push_dat;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head entry and status flags
  always_comb begin
    o_head_dat = r_mem[r_rd_ptr];
    o_vld      = (r_count != '0);
    o_full     = (r_count == (AW+1)'(DEPTH));
  end

endmodule

// File: rtl/bep_frame_controller.sv
// Frame sequencer behind the Manchester decoder: sync hunt, length, payload, checksum.
// Latency: payload byte at FIFO head 1 cycle after its last bit; frame_ok/frame_error 1 cycle after the deciding bit.
// Backpressure: host pops via byte_valid/byte_ready; a payload byte arriving to a full FIFO aborts the frame.
module bep_frame_controller
  import bep_frame_controller_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int         MAX_LEN        = MAX_LEN_DEF,
  parameter int         TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int         FIFO_DEPTH     = FIFO_DEPTH_DEF
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_bit_valid,
  input  logic       i_bit_data,
  input  logic       i_transmission_begin,
  output logic       o_decoder_reset_n,
  output logic [7:0] o_byte_data,
  output logic       o_byte_first,
  output logic       o_byte_last,
  output logic       o_byte_valid,
  input  logic       i_byte_ready,
  output logic       o_frame_ok,
  output logic       o_frame_error,
  output logic [1:0] o_error_code,
  output logic       o_busy
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  state_t      r_state;
  state_t      w_next_state;

  // Only the low seven bits of the shift register are ever needed: the
  // full byte is always formed together with the incoming bit.
  logic [6:0]    r_sr;
  logic [2:0]    r_bit_cnt;
  logic [TW-1:0] r_timer;
  logic [7:0]    r_csum;
  logic [LW-1:0] r_remaining;
  logic          r_first;
  logic          r_rec_cnt;
  logic          r_frame_ok;
  logic          r_frame_error;
  logic [1:0]    r_error_code;

  logic [7:0]  w_byte;
  logic        w_in_frame;
  logic        w_in_body;
  logic        w_byte_done;
  logic        w_timeout;
  logic        w_pop;
  logic        w_fifo_full;
  logic        w_fifo_vld;
  logic        w_push;
  logic        w_ok;
  logic        w_err;
  logic [1:0]  w_err_code;
  fifo_entry_t w_push_entry;
  fifo_entry_t w_head;

  // Byte assembly and frame-phase qualifiers
  always_comb begin
    w_byte      = {r_sr, i_bit_data};
    w_in_frame  = (r_state == ST_HUNT) || (r_state == ST_LENGTH) ||
                  (r_state == ST_PAYLOAD) || (r_state == ST_CHECK);
    w_in_body   = (r_state == ST_LENGTH) || (r_state == ST_PAYLOAD) ||
                  (r_state == ST_CHECK);
    w_byte_done = i_bit_valid & w_in_body & (r_bit_cnt == 3'd7);
    // A bit strobe in the same cycle always rescues the frame
    w_timeout   = w_in_frame & ~i_bit_valid &
                  (r_timer == TW'(TIMEOUT_CYCLES - 1));
    w_pop       = w_fifo_vld & i_byte_ready;
  end

  // State register
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state plus the frame events that drive it
  always_comb begin
    w_next_state = r_state;
    w_err        = 1'b0;
    w_err_code   = r_error_code;
    w_ok         = 1'b0;
    w_push       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_transmission_begin) begin
          w_next_state = ST_HUNT;
        end
      end
      ST_HUNT: begin
        if (w_timeout) begin
          w_err      = 1'b1;
          w_err_code = ERR_TIMEOUT;
        end else if (i_bit_valid && (w_byte == SYNC_BYTE)) begin
          w_next_state = ST_LENGTH;
        end
      end
      ST_LENGTH, ST_PAYLOAD, ST_CHECK: begin
        if (i_transmission_begin) begin
          // Decoder re-armed mid-frame: the line dropped out
          w_err      = 1'b1;
          w_err_code = ERR_TIMEOUT;
        end else if (w_byte_done) begin
          if (r_state == ST_LENGTH) begin
            if ((w_byte == 8'd0) || (w_byte > 8'(MAX_LEN))) begin
              w_err      = 1'b1;
              w_err_code = ERR_LENGTH;
            end else begin
              w_next_state = ST_PAYLOAD;
            end
          end else if (r_state == ST_PAYLOAD) begin
            if (w_fifo_full && !w_pop) begin
              w_err      = 1'b1;
              w_err_code = ERR_OVERFLOW;
            end else begin
              w_push = 1'b1;
              if (r_remaining == LW'(1)) begin
                w_next_state = ST_CHECK;
              end
            end
          end else begin
            if (w_byte == r_csum) begin
              w_ok         = 1'b1;
              w_next_state = ST_IDLE;
            end else begin
              w_err      = 1'b1;
              w_err_code = ERR_CSUM;
            end
          end
        end else if (w_timeout) begin
          w_err      = 1'b1;
          w_err_code = ERR_TIMEOUT;
        end
      end
      ST_RECOVER: begin
        if (r_rec_cnt) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
    if (w_err) begin
      w_next_state = ST_RECOVER;
    end
  end

  // Datapath: shift register, bit counter, idle timer, length/checksum tracking, event pulses
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sr          <= '0;
      r_bit_cnt     <= '0;
      r_timer       <= '0;
      r_csum        <= '0;
      r_remaining   <= '0;
      r_first       <= 1'b0;
      r_rec_cnt     <= 1'b0;
      r_frame_ok    <= 1'b0;
      r_frame_error <= 1'b0;
      r_error_code  <= ERR_TIMEOUT;
    end else begin
      r_frame_ok    <= w_ok;
      r_frame_error <= w_err;
      if (w_err) begin
        r_error_code <= w_err_code;
      end

      if (w_in_frame && !i_bit_valid) begin
        r_timer <= r_timer + TW'(1);
      end else begin
        r_timer <= '0;
      end

      if (!w_in_frame) begin
        r_sr <= '0;
      end else if (i_bit_valid) begin
        r_sr <= w_byte[6:0];
      end

      if (!w_in_body) begin
        r_bit_cnt <= '0;
      end else if (i_bit_valid) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end

      if (r_state == ST_LENGTH && w_byte_done && !w_err) begin
        r_remaining <= w_byte[LW-1:0];
        r_csum      <= w_byte;
        r_first     <= 1'b1;
      end else if (w_push) begin
        r_remaining <= r_remaining - LW'(1);
        r_csum      <= r_csum ^ w_byte;
        r_first     <= 1'b0;
      end

      if (r_state == ST_RECOVER) begin
        r_rec_cnt <= ~r_rec_cnt;
      end else begin
        r_rec_cnt <= 1'b0;
      end
    end
  end

  // Entry pushed into the payload buffer
  always_comb begin
    w_push_entry.first = r_first;
    w_push_entry.last  = (r_remaining == LW'(1));
    w_push_entry.data  = w_byte;
  end

  bep_frame_controller_byte_fifo #(
    .WIDTH ($bits(fifo_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_byte_fifo (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_push     (w_push),
    .i_push_dat (w_push_entry),
    .i_pop      (w_pop),
    .o_head_dat (w_head),
    .o_vld      (w_fifo_vld),
    .o_full     (w_fifo_full)
  );

  // Outputs decoded from state and registered events
  always_comb begin
    o_busy            = (r_state != ST_IDLE);
    o_decoder_reset_n = (r_state != ST_RECOVER);
    o_frame_ok        = r_frame_ok;
    o_frame_error     = r_frame_error;
    o_error_code      = r_error_code;
    o_byte_valid      = w_fifo_vld;
    o_byte_data       = w_head.data;
    o_byte_first      = w_head.first;
    o_byte_last       = w_head.last;
  end

endmodule

// File: tb/tb_bep_frame_controller.sv
// Directed bench for the BEP frame controller: vector table of whole frames plus timing corner cases.
module tb_bep_frame_controller;
  import bep_frame_controller_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_valid;
  logic       bit_data;
  logic       tx_begin;
  logic       dec_rst_n;
  logic [7:0] byte_data;
  logic       byte_first;
  logic       byte_last;
  logic       byte_valid;
  logic       byte_ready;
  logic       frame_ok;
  logic       frame_error;
  logic [1:0] error_code;
  logic       busy;

  always #5 clk = ~clk;

  bep_frame_controller dut (
    .i_clock              (clk),
    .i_reset              (rst),
    .i_bit_valid          (bit_valid),
    .i_bit_data           (bit_data),
    .i_transmission_begin (tx_begin),
    .o_decoder_reset_n    (dec_rst_n),
    .o_byte_data          (byte_data),
    .o_byte_first         (byte_first),
    .o_byte_last          (byte_last),
    .o_byte_valid         (byte_valid),
    .i_byte_ready         (byte_ready),
    .o_frame_ok           (frame_ok),
    .o_frame_error        (frame_error),
    .o_error_code         (error_code),
    .o_busy               (busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Running event totals, sampled on the falling edge
  int         mon_ok  = 0;
  int         mon_err = 0;
  int         mon_low = 0;
  logic [9:0] mon_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_ok)    mon_ok  <= mon_ok + 1;
      if (frame_error) mon_err <= mon_err + 1;
      if (!dec_rst_n)  mon_low <= mon_low + 1;
      if (byte_valid && byte_ready) mon_q.push_back({byte_first, byte_last, byte_data});
    end
  end

  typedef struct {
    logic [7:0] bytes [8];
    int         nbytes;
    int         exp_ok;
    int         exp_err;
    int         exp_code;
    int         exp_nout;
    logic [9:0] exp_out [4];
  } vec_t;

  localparam int NV = 6;
  vec_t vecs [NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse_bit(input logic b);
    bit_valid = 1'b1;
    bit_data  = b;
    tick();
    bit_valid = 1'b0;
    bit_data  = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    pulse_bit(b);
    repeat (BIT_PERIOD - 1) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic begin_tx();
    tx_begin = 1'b1;
    tick();
    tx_begin = 1'b0;
  endtask

  int ok0, err0, low0, q0;

  task automatic snap();
    ok0  = mon_ok;
    err0 = mon_err;
    low0 = mon_low;
    q0   = mon_q.size();
  endtask

  initial begin
    // {first,last,data} encoding: bit9 = first, bit8 = last
    vecs[0].bytes = '{8'hD5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03, 8'h00, 8'h00};  // csum 03^11^22^33 = 03
    vecs[0].nbytes = 6; vecs[0].exp_ok = 1; vecs[0].exp_err = 0; vecs[0].exp_code = 0;
    vecs[0].exp_nout = 3; vecs[0].exp_out = '{10'h211, 10'h022, 10'h133, 10'h000};

    vecs[1].bytes = '{8'hAA, 8'hAA, 8'hD5, 8'h02, 8'h5A, 8'hA5, 8'hFD, 8'h00};  // csum 02^5A^A5 = FD
    vecs[1].nbytes = 7; vecs[1].exp_ok = 1; vecs[1].exp_err = 0; vecs[1].exp_code = 0;
    vecs[1].exp_nout = 2; vecs[1].exp_out = '{10'h25A, 10'h1A5, 10'h000, 10'h000};

    vecs[2].bytes = '{8'hD5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[2].nbytes = 2; vecs[2].exp_ok = 0; vecs[2].exp_err = 1; vecs[2].exp_code = 1;
    vecs[2].exp_nout = 0; vecs[2].exp_out = '{10'h000, 10'h000, 10'h000, 10'h000};

    vecs[3].bytes = '{8'hD5, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};  // length 17
    vecs[3].nbytes = 2; vecs[3].exp_ok = 0; vecs[3].exp_err = 1; vecs[3].exp_code = 1;
    vecs[3].exp_nout = 0; vecs[3].exp_out = '{10'h000, 10'h000, 10'h000, 10'h000};

    vecs[4].bytes = '{8'hD5, 8'h01, 8'h7E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};  // csum should be 7F
    vecs[4].nbytes = 4; vecs[4].exp_ok = 0; vecs[4].exp_err = 1; vecs[4].exp_code = 2;
    vecs[4].exp_nout = 1; vecs[4].exp_out = '{10'h37E, 10'h000, 10'h000, 10'h000};

    vecs[5].bytes = '{8'hD5, 8'h01, 8'hA5, 8'hA4, 8'h00, 8'h00, 8'h00, 8'h00};  // csum 01^A5 = A4
    vecs[5].nbytes = 4; vecs[5].exp_ok = 1; vecs[5].exp_err = 0; vecs[5].exp_code = 0;
    vecs[5].exp_nout = 1; vecs[5].exp_out = '{10'h3A5, 10'h000, 10'h000, 10'h000};

    rst = 1'b1; bit_valid = 1'b0; bit_data = 1'b0; tx_begin = 1'b0; byte_ready = 1'b1;
    repeat (3) tick();
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst byte_valid", 32'(byte_valid), 32'd0);
    chk("rst frame_ok", 32'(frame_ok), 32'd0);
    chk("rst frame_error", 32'(frame_error), 32'd0);
    chk("rst error_code", 32'(error_code), 32'd0);
    chk("rst dec_rst_n", 32'(dec_rst_n), 32'd1);
    rst = 1'b0;
    repeat (2) tick();

    // Whole-frame vectors with the consumer always ready
    for (int v = 0; v < NV; v++) begin
      snap();
      begin_tx();
      for (int b = 0; b < vecs[v].nbytes; b++) send_byte(vecs[v].bytes[b]);
      repeat (30) tick();
      chk($sformatf("v%0d frame_ok count", v), 32'(mon_ok - ok0), 32'(vecs[v].exp_ok));
      chk($sformatf("v%0d frame_error count", v), 32'(mon_err - err0), 32'(vecs[v].exp_err));
      chk($sformatf("v%0d decoder reset low cycles", v), 32'(mon_low - low0), 32'(2 * vecs[v].exp_err));
      if (vecs[v].exp_err != 0)
        chk($sformatf("v%0d error_code", v), 32'(error_code), 32'(vecs[v].exp_code));
      chk($sformatf("v%0d bytes out", v), 32'(mon_q.size() - q0), 32'(vecs[v].exp_nout));
      for (int k = 0; k < vecs[v].exp_nout; k++)
        chk($sformatf("v%0d byte %0d", v, k), 32'(mon_q[q0 + k]), 32'(vecs[v].exp_out[k]));
      chk($sformatf("v%0d busy after", v), 32'(busy), 32'd0);
    end

    // Byte latency, hold stability and frame_ok timing
    byte_ready = 1'b0;
    snap();
    begin_tx();
    send_byte(8'hD5);
    send_byte(8'h01);
    for (int i = 7; i >= 1; i--) send_bit(1'(8'h3C >> i));
    chk("lat valid before last bit", 32'(byte_valid), 32'd0);
    pulse_bit(1'b0);
    chk("lat valid after last bit", 32'(byte_valid), 32'd1);
    chk("lat head", 32'({byte_first, byte_last, byte_data}), 32'h33C);
    repeat (5) tick();
    chk("hold head", 32'({byte_valid, byte_first, byte_last, byte_data}), 32'h73C);
    repeat (12) tick();
    for (int i = 7; i >= 1; i--) send_bit(1'(8'h3D >> i));
    chk("ok before last bit", 32'(frame_ok), 32'd0);
    pulse_bit(1'b1);
    chk("ok pulse", 32'(frame_ok), 32'd1);
    tick();
    chk("ok one cycle", 32'(frame_ok), 32'd0);
    byte_ready = 1'b1;
    repeat (5) tick();
    chk("lat decoder reset never low", 32'(mon_low - low0), 32'd0);
    chk("lat popped", 32'(mon_q.size() - q0), 32'd1);

    // Timeout on the 40th clock without a strobe
    snap();
    begin_tx();
    send_byte(8'hD5);
    send_byte(8'h02);
    pulse_bit(1'b1);
    repeat (39) tick();
    chk("timeout not yet", 32'(frame_error), 32'd0);
    tick();
    chk("timeout error", 32'(frame_error), 32'd1);
    chk("timeout code", 32'(error_code), 32'(ERR_TIMEOUT));
    repeat (10) tick();
    chk("timeout low cycles", 32'(mon_low - low0), 32'd2);

    // Strobe on clock 39 keeps the frame alive
    snap();
    begin_tx();
    send_byte(8'hD5);
    send_byte(8'h02);
    pulse_bit(1'b1);
    repeat (38) tick();
    pulse_bit(1'b0);
    repeat (38) tick();
    chk("strobe at 39 no error", 32'(mon_err - err0), 32'd0);
    repeat (40) tick();

    // Overflow with consumer stalled
    byte_ready = 1'b0;
    snap();
    begin_tx();
    send_byte(8'hD5);
    send_byte(8'h05);
    for (int b = 1; b <= 5; b++) send_byte(8'(b));
    chk("ovf error count", 32'(mon_err - err0), 32'd1);
    chk("ovf code", 32'(error_code), 32'(ERR_OVERFLOW));
    chk("ovf valid held", 32'(byte_valid), 32'd1);
    byte_ready = 1'b1;
    repeat (10) tick();
    chk("ovf drained", 32'(mon_q.size() - q0), 32'd4);
    chk("ovf byte 0", 32'(mon_q[q0]), 32'h201);
    chk("ovf byte 3", 32'(mon_q[q0 + 3]), 32'h004);
    chk("ovf empty", 32'(byte_valid), 32'd0);

    // Reset in the middle of a payload discards everything
    byte_ready = 1'b0;
    begin_tx();
    send_byte(8'hD5);
    send_byte(8'h05);
    send_byte(8'h01);
    send_byte(8'h02);
    rst = 1'b1;
    tick();
    chk("mid rst valid", 32'(byte_valid), 32'd0);
    chk("mid rst busy", 32'(busy), 32'd0);
    chk("mid rst code", 32'(error_code), 32'd0);
    chk("mid rst flags", 32'({frame_ok, frame_error, dec_rst_n}), 32'b001);
    rst = 1'b0;
    snap();
    byte_ready = 1'b1;
    repeat (5) tick();
    chk("mid rst nothing popped", 32'(mon_q.size() - q0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
